// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade input front end.
// Contents: key-latch indices, PS/2 scan codes as {extended, code},
// joystick bit positions, rotate encodings, direction bit order
// {up,down,left,right}, the coin FSM state type, and small helpers for
// scan-code decode, rotation and opposing-direction cleaning.
package arcade_input_pkg;

  // Key latch indices
  localparam int unsigned KeyP0Up    = 0;
  localparam int unsigned KeyP0Down  = 1;
  localparam int unsigned KeyP0Left  = 2;
  localparam int unsigned KeyP0Right = 3;
  localparam int unsigned KeyP0FireA = 4;   // space
  localparam int unsigned KeyP0FireB = 5;   // left ctrl
  localparam int unsigned KeyP0Start = 6;
  localparam int unsigned KeyP1Up    = 7;
  localparam int unsigned KeyP1Down  = 8;
  localparam int unsigned KeyP1Left  = 9;
  localparam int unsigned KeyP1Right = 10;
  localparam int unsigned KeyP1Fire  = 11;
  localparam int unsigned KeyP1Start = 12;
  localparam int unsigned KeyP2Start = 13;
  localparam int unsigned KeyP3Start = 14;
  localparam int unsigned KeyCoin0   = 15;
  localparam int unsigned KeyCoin1   = 16;
  localparam int unsigned NumKeys    = 17;

  // Scan codes, bit 8 is the E0 extended flag
  localparam logic [8:0] ScP0Up    = 9'h175;
  localparam logic [8:0] ScP0Down  = 9'h172;
  localparam logic [8:0] ScP0Left  = 9'h16B;
  localparam logic [8:0] ScP0Right = 9'h174;
  localparam logic [8:0] ScP0FireA = 9'h029;
  localparam logic [8:0] ScP0FireB = 9'h014;
  localparam logic [8:0] ScP0Start = 9'h005;
  localparam logic [8:0] ScP1Up    = 9'h02D;
  localparam logic [8:0] ScP1Down  = 9'h02B;
  localparam logic [8:0] ScP1Left  = 9'h023;
  localparam logic [8:0] ScP1Right = 9'h034;
  localparam logic [8:0] ScP1Fire  = 9'h01C;
  localparam logic [8:0] ScP1Start = 9'h006;
  localparam logic [8:0] ScP2Start = 9'h004;
  localparam logic [8:0] ScP3Start = 9'h00C;
  localparam logic [8:0] ScCoin0   = 9'h02E;
  localparam logic [8:0] ScCoin1   = 9'h036;

  // Joystick bit positions within a 16-bit player slice
  localparam int unsigned JoyRight = 0;
  localparam int unsigned JoyLeft  = 1;
  localparam int unsigned JoyDown  = 2;
  localparam int unsigned JoyUp    = 3;
  localparam int unsigned JoyFire  = 4;
  localparam int unsigned JoyStart = 5;
  localparam int unsigned JoyCoin  = 7;

  // Rotate encodings
  localparam logic [1:0] RotNone  = 2'd0;
  localparam logic [1:0] RotCw90  = 2'd1;
  localparam logic [1:0] Rot180   = 2'd2;
  localparam logic [1:0] RotCcw90 = 2'd3;

  // Direction tuple bit order {up,down,left,right}
  localparam int unsigned DirRight = 0;
  localparam int unsigned DirLeft  = 1;
  localparam int unsigned DirDown  = 2;
  localparam int unsigned DirUp    = 3;

  typedef enum logic [1:0] {StIdle, StPulse, StWaitRel} coin_state_e;

  // One-hot latch select for a scan code; unknown codes give zero
  function automatic logic [NumKeys-1:0] key_decode(input logic [8:0] sc);
    logic [NumKeys-1:0] m;
    m = '0;
    case (sc)
      ScP0Up:    m[KeyP0Up]    = 1'b1;
      ScP0Down:  m[KeyP0Down]  = 1'b1;
      ScP0Left:  m[KeyP0Left]  = 1'b1;
      ScP0Right: m[KeyP0Right] = 1'b1;
      ScP0FireA: m[KeyP0FireA] = 1'b1;
      ScP0FireB: m[KeyP0FireB] = 1'b1;
      ScP0Start: m[KeyP0Start] = 1'b1;
      ScP1Up:    m[KeyP1Up]    = 1'b1;
      ScP1Down:  m[KeyP1Down]  = 1'b1;
      ScP1Left:  m[KeyP1Left]  = 1'b1;
      ScP1Right: m[KeyP1Right] = 1'b1;
      ScP1Fire:  m[KeyP1Fire]  = 1'b1;
      ScP1Start: m[KeyP1Start] = 1'b1;
      ScP2Start: m[KeyP2Start] = 1'b1;
      ScP3Start: m[KeyP3Start] = 1'b1;
      ScCoin0:   m[KeyCoin0]   = 1'b1;
      ScCoin1:   m[KeyCoin1]   = 1'b1;
      default:   m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] rotate_dir(input logic [3:0] d, input logic [1:0] rot);
    logic u, dn, l, r;
    u  = d[DirUp];
    dn = d[DirDown];
    l  = d[DirLeft];
    r  = d[DirRight];
    case (rot)
      RotCw90:  return {l, r, dn, u};
      Rot180:   return {dn, u, r, l};
      RotCcw90: return {r, l, u, dn};
      default:  return d;
    endcase
  endfunction

  // Opposing pairs cancel so the core never sees an impossible stick
  function automatic logic [3:0] clean_dir(input logic [3:0] d);
    logic [3:0] o;
    o = d;
    if (d[DirUp] && d[DirDown]) begin
      o[DirUp]   = 1'b0;
      o[DirDown] = 1'b0;
    end
    if (d[DirLeft] && d[DirRight]) begin
      o[DirLeft]  = 1'b0;
      o[DirRight] = 1'b0;
    end
    return o;
  endfunction

endpackage

// File: rtl/arcade_input_mapper_coin_pulser.sv
// Fixed-length coin pulse generator.
// Ports: clk_i system clock; reset_i synchronous active-high reset;
//        coin_req_i level coin request; coin_out_o registered pulse,
//        high for exactly COIN_PULSE cycles per request edge.
// A held request fires once; it must drop before another pulse can start.
module coin_pulser
  import arcade_input_pkg::*;
#(
  parameter int unsigned COIN_PULSE = 2400000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic coin_req_i,
  output logic coin_out_o
);

  localparam int unsigned CntW = $clog2(COIN_PULSE);
  localparam logic [CntW-1:0] CntLast = CntW'(COIN_PULSE - 1);

  coin_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            coin_q, coin_d;
  logic            prev_req_q, prev_req_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    coin_d     = coin_q;
    prev_req_d = coin_req_i;
    unique case (state_q)
      StIdle: begin
        if (coin_req_i && !prev_req_q) begin
          coin_d  = 1'b1;
          cnt_d   = CntLast;
          state_d = StPulse;
        end
      end
      StPulse: begin
        if (cnt_q == '0) begin
          coin_d  = 1'b0;
          state_d = StWaitRel;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWaitRel: begin
        if (!coin_req_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      coin_q     <= 1'b0;
      prev_req_q <= 1'b1;  // a request still held through reset must be released first
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      coin_q     <= coin_d;
      prev_req_q <= prev_req_d;
    end
  end

  assign coin_out_o = coin_q;

endmodule

// File: rtl/arcade_input_mapper.sv
// Player-input front end: PS/2 key latches merged with joysticks, rotated,
// cleaned of opposing directions, with autofire and a coin pulse.
// Ports: clk_sys clock; reset sync active-high; ps2_key {toggle,pressed,
//        ext,code}; joystick 16 bits/player; rotate 0/90/180/270;
//        autofire_en per player; p_dir {U,D,L,R}/player; p_fire; p_start;
//        coin_out. All outputs are registered.
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int unsigned PLAYERS    = 2,
  parameter int unsigned COIN_PULSE = 2400000,
  parameter int unsigned AF_HALF    = 800000,
  parameter bit          START_COIN = 1'b0
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [10:0]             ps2_key,
  input  logic [16*PLAYERS-1:0]   joystick,
  input  logic [1:0]              rotate,
  input  logic [PLAYERS-1:0]      autofire_en,
  output logic [4*PLAYERS-1:0]    p_dir,
  output logic [PLAYERS-1:0]      p_fire,
  output logic [PLAYERS-1:0]      p_start,
  output logic                    coin_out
);

  localparam int unsigned AfW = $clog2(AF_HALF);
  localparam logic [AfW-1:0] AfLast = AfW'(AF_HALF - 1);

  logic               old_toggle_q, old_toggle_d;
  logic [NumKeys-1:0] key_q, key_d, key_hit;
  logic [AfW-1:0]     af_cnt_q, af_cnt_d;
  logic               af_phase_q, af_phase_d;
  logic [4*PLAYERS-1:0] p_dir_q, p_dir_d;
  logic [PLAYERS-1:0] p_fire_q, p_fire_d, p_start_q, p_start_d;
  logic [3:0][3:0]    kb_dir;    // sized for 4 players so indexing is always in range
  logic [3:0]         kb_fire, kb_start;
  logic [15:0]        joy;
  logic [3:0]         raw_dir;
  logic               fire_raw, start_raw, any_start, coin_req;
  logic [PLAYERS-1:0] unused_joy_bits;

  // Key event: toggle differs from the last seen value
  always_comb begin
    old_toggle_d = ps2_key[10];
    key_hit      = (ps2_key[10] != old_toggle_q) ? key_decode(ps2_key[8:0]) : '0;
    key_d        = (key_q & ~key_hit) | (key_hit & {NumKeys{ps2_key[9]}});
  end

  always_comb begin
    kb_dir   = '0;
    kb_fire  = '0;
    kb_start = '0;
    kb_dir[0]   = {key_q[KeyP0Up], key_q[KeyP0Down], key_q[KeyP0Left], key_q[KeyP0Right]};
    kb_fire[0]  = key_q[KeyP0FireA] | key_q[KeyP0FireB];
    kb_start[0] = key_q[KeyP0Start];
    kb_dir[1]   = {key_q[KeyP1Up], key_q[KeyP1Down], key_q[KeyP1Left], key_q[KeyP1Right]};
    kb_fire[1]  = key_q[KeyP1Fire];
    kb_start[1] = key_q[KeyP1Start];
    kb_start[2] = key_q[KeyP2Start];
    kb_start[3] = key_q[KeyP3Start];
  end

  always_comb begin
    p_dir_d         = '0;
    p_fire_d        = '0;
    p_start_d       = '0;
    joy             = '0;
    raw_dir         = '0;
    fire_raw        = 1'b0;
    start_raw       = 1'b0;
    any_start       = 1'b0;
    coin_req        = key_q[KeyCoin0] | key_q[KeyCoin1];
    unused_joy_bits = '0;
    for (int unsigned p = 0; p < PLAYERS; p++) begin
      joy       = joystick[16*p +: 16];
      raw_dir   = kb_dir[p] | joy[JoyUp:JoyRight];
      fire_raw  = kb_fire[p] | joy[JoyFire];
      start_raw = kb_start[p] | joy[JoyStart];
      p_dir_d[4*p +: 4] = clean_dir(rotate_dir(raw_dir, rotate));
      p_fire_d[p]  = fire_raw & (autofire_en[p] ? af_phase_q : 1'b1);
      p_start_d[p] = start_raw;
      any_start    = any_start | start_raw;
      coin_req     = coin_req | joy[JoyCoin];
      unused_joy_bits[p] = ^{joy[15:8], joy[6]};
    end
    coin_req = coin_req | (START_COIN & any_start);
  end

  // Shared autofire phase, inverted once per AF_HALF cycles
  always_comb begin
    af_cnt_d   = (af_cnt_q == AfLast) ? '0 : af_cnt_q + 1'b1;
    af_phase_d = af_phase_q ^ (af_cnt_q == AfLast);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      old_toggle_q <= ps2_key[10];  // swallow whatever toggle level is present at reset
      key_q        <= '0;
      af_cnt_q     <= '0;
      af_phase_q   <= 1'b1;
      p_dir_q      <= '0;
      p_fire_q     <= '0;
      p_start_q    <= '0;
    end else begin
      old_toggle_q <= old_toggle_d;
      key_q        <= key_d;
      af_cnt_q     <= af_cnt_d;
      af_phase_q   <= af_phase_d;
      p_dir_q      <= p_dir_d;
      p_fire_q     <= p_fire_d;
      p_start_q    <= p_start_d;
    end
  end

  coin_pulser #(
    .COIN_PULSE(COIN_PULSE)
  ) u_coin_pulser (
    .clk_i     (clk_sys),
    .reset_i   (reset),
    .coin_req_i(coin_req),
    .coin_out_o(coin_out)
  );

  assign p_dir   = p_dir_q;
  assign p_fire  = p_fire_q;
  assign p_start = p_start_q;

endmodule

// File: doc/arcade_input_mapper.md
Name: arcade_input_mapper

Overview:
- Parametrised player-input front end for arcade cores. Sits between hps_io (keyboard and joysticks) and the machine core's active-low IN registers.
- Decodes PS/2 make/break events into latched keys and merges them with N joysticks.
- Applies per-core rotation (0/90/180/270) and opposing-direction cleaning, then produces per-player direction, fire and start.
- Generates a fixed-length coin pulse, plus optional per-player autofire.

Parameters:
- PLAYERS, 2, number of player channels (1..4); keyboard maps to players 0 and 1 only.
- COIN_PULSE, 2400000, coin_out high time in clk_sys cycles (100 ms at 24 MHz).
- AF_HALF, 800000, autofire half-period in clk_sys cycles.
- START_COIN, 0, 1 = any start press also requests a coin (legacy single-button behaviour).

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high
- ps2_key  in  11  [10] toggle on each event, [9] pressed, [8] extended (E0), [7:0] scan code
- joystick  in  16*PLAYERS  packed, 16 bits per player; bit0 right, 1 left, 2 down, 3 up, 4 fire, 5 start, 7 coin
- rotate  in  2  0 none, 1 CW90, 2 180, 3 CCW90
- autofire_en  in  PLAYERS  per-player autofire enable
- p_dir  out  4*PLAYERS  per player {up,down,left,right}, active-high
- p_fire  out  PLAYERS  fire after autofire gating
- p_start  out  PLAYERS  start buttons
- coin_out  out  1  coin pulse

Behaviour:
- Clock and reset: one clock (clk_sys). Reset is synchronous, active-high. On reset all key latches, outputs, counters and coin_out go to 0, autofire phase goes to 1, and old_toggle loads ps2_key[10] so no spurious event fires.
- Key event detection: a key event occurs when ps2_key[10] != old_toggle; old_toggle then updates.
  - The matching latch loads ps2_key[9]. Unmatched codes are ignored.
  - Multiple events need at least 1 cycle between toggles.
- Keyboard map, player 0: up E0-75, down E0-72, left E0-6B, right E0-74, fire 29 (space) or 14 (left ctrl, non-extended only), start 05 (F1).
- Keyboard map, player 1: up 2D (R), down 2B (F), left 23 (D), right 34 (G), fire 1C (A), start 06 (F2).
- Keyboard map, starts for players 2 and 3: 04 (F3) and 0C (F4).
- Keyboard map, coins: 2E (5) and 36 (6).
- Merge: raw_p = key latches OR joystick slice p.
- Rotation, from raw {U,D,L,R} to out:
  - rotate=0: identity.
  - rotate=1: up=L, down=R, left=D, right=U.
  - rotate=2: up=D, down=U, left=R, right=L.
  - rotate=3: up=R, down=L, left=U, right=D.
- Cleaning: after rotation, up and down both 1 gives both 0; left and right both 1 gives both 0.
- Autofire:
  - A single shared counter counts 0..AF_HALF-1; at wrap the phase inverts.
  - p_fire[p] = fire_raw & (autofire_en[p] ? phase : 1).
  - Changing autofire_en mid-hold takes effect on the next registered cycle.
- Coin request: coin_req = any joystick coin bit | coin key latches | (START_COIN & any start).
- Coin pulse state machine (IDLE, PULSE, WAIT_REL):
  - IDLE: on coin_req rising edge (versus last cycle's coin_req), set coin_out=1, load counter to COIN_PULSE-1, go to PULSE.
  - PULSE: decrement; at 0, drop coin_out and go to WAIT_REL. New requests during PULSE are ignored.
  - WAIT_REL: stay until coin_req=0, then go to IDLE. A held coin therefore never re-triggers.
- Latency: all outputs are registered, valid 1 cycle after the input (2 cycles from ps2_key toggle: event latch, then output register).
- Reset mid-pulse: coin_out is 0 on the next edge and the state goes to IDLE. If coin_req is still held after reset, no pulse occurs until it is released, because prev coin_req resets to 1.
- Widths: counters are sized with $clog2 of their parameter. COIN_PULSE and AF_HALF must be ≥ 2.

Decomposition:
- Package arcade_input_pkg: scan-code constants (extended flag included), joystick bit indices, rotate encoding constants, and the direction-tuple index order {up,down,left,right}.
- One sub-module, coin_pulser: the IDLE/PULSE/WAIT_REL state machine and down-counter, with parameter COIN_PULSE.
- The keyboard latch and rotation logic stay inline.

Test Plan:
- Reset with ps2_key[10]=1 -> no latch changes; all outputs 0, coin_out 0.
- Key event {toggle flip, pressed=1, ext=1, 75}, rotate=0 -> p_dir[3:0]=1000 two cycles later; break event -> 0000.
- Joystick0=0x0008 (up) with rotate=1,2,3 -> p_dir[3:0]=0001, 0100, 0010 respectively.
- Joystick0=0x000C (up+down) plus left key -> p_dir[3:0]=0010 (up and down cancelled).
- COIN_PULSE=10: joystick1 bit7 held for 50 cycles -> exactly one coin_out pulse of 10 cycles, no retrigger; release, press again -> second pulse. Reset asserted at pulse cycle 4 -> coin_out 0 the next cycle.
- AF_HALF=4, autofire_en=01, both fires held -> p_fire[0] toggles every 4 cycles starting high; p_fire[1] steady 1.
